// File: rtl/mips_multicycle_control_pkg.sv
// Shared types for the MIPS multi-cycle control unit: state encoding,
// opcode values, ALU / PC-source / trap-cause encodings and the
// internal control word passed from the decoder to the top.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       trap;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Bundle between the control unit (master) and the multi-cycle datapath /
// memory side (slave): opcode and memory-ready in, control strobes out.
interface mips_multicycle_control_if #(parameter int ALU_OP_W = 2);
  logic [5:0]          opcode;
  logic                mem_ready;
  logic                pc_write, pc_write_eq, pc_write_ne;
  logic                i_or_d, mem_read, mem_write, ir_write;
  logic                reg_dst, reg_write, mem_to_reg;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [1:0]          pc_source;
  logic                instr_done, trap;
  logic [1:0]          trap_cause;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_source, instr_done, trap, trap_cause
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_source, instr_done, trap, trap_cause
  );
endinterface

// File: rtl/mips_multicycle_control_decode.sv
// Combinational state-to-control-word decoder (module mc_ctrl_decode).
// Moore outputs per state; only ir_write/pc_write in FETCH and instr_done
// in MEM_WR are gated by mem_ready. JUMP decode exists only with MC_CTRL_JUMP_EN.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // Control word for the current state; everything defaults to 0.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = 2'b01;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: ctrl_o.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
      end
      S_I_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a   = 1'b1;
        ctrl_o.alu_op      = ALU_SUB;
        ctrl_o.pc_source   = PC_ALUOUT;
        ctrl_o.pc_write_eq = (opcode_i == OP_BEQ);
        ctrl_o.pc_write_ne = (opcode_i == OP_BNE);
        ctrl_o.instr_done  = 1'b1;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
`endif
      S_TRAP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PC_EXC;
        ctrl_o.trap       = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, opcode dispatch, memory wait
// counter with bus-timeout trap. Optional JUMP support via MC_CTRL_JUMP_EN.
// Latency 3-5 cycles per instruction plus one per memory wait cycle.
module mips_multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALU_OP_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mips_multicycle_control_if.master  bus
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       wait_state;
  logic       timeout;
  ctrl_t      ctrl;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                      (state_q == S_MEM_WR);
  // Ready arriving on the final allowed wait cycle still completes.
  assign timeout = wait_state && !bus.mem_ready &&
                   (cnt_q == 8'(MEM_TIMEOUT - 1));

  // State, wait counter and trap cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= 8'd0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next-state dispatch, trap cause capture and wait counting.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = (wait_state && !bus.mem_ready && !timeout) ? cnt_q + 8'd1 : 8'd0;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_RTYPE:       state_d = S_R_EXEC;
          OP_ADDI:        state_d = S_I_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
          OP_J:           state_d = S_JUMP;
`endif
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_TRAP: begin
        state_d = S_FETCH;
        cause_d = CAUSE_NONE;
      end
      default:    state_d = S_FETCH;
    endcase
    if (timeout) begin
      state_d = S_TRAP;
      cause_d = CAUSE_BUS;
    end
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.pc_write    = ctrl.pc_write;
  assign bus.pc_write_eq = ctrl.pc_write_eq;
  assign bus.pc_write_ne = ctrl.pc_write_ne;
  assign bus.i_or_d      = ctrl.i_or_d;
  assign bus.mem_read    = ctrl.mem_read;
  assign bus.mem_write   = ctrl.mem_write;
  assign bus.ir_write    = ctrl.ir_write;
  assign bus.reg_dst     = ctrl.reg_dst;
  assign bus.reg_write   = ctrl.reg_write;
  assign bus.mem_to_reg  = ctrl.mem_to_reg;
  assign bus.alu_src_a   = ctrl.alu_src_a;
  assign bus.alu_src_b   = ctrl.alu_src_b;
  assign bus.alu_op      = ALU_OP_W'(ctrl.alu_op);
  assign bus.pc_source   = ctrl.pc_source;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.trap        = ctrl.trap;
  assign bus.trap_cause  = cause_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-cycle vector table
// through a scoreboard queue, plus an async-reset sequence during a write wait.
module tb_mips_multicycle_control;

  localparam int TO = 4;

  typedef struct packed {
    logic       pcw, pceq, pcne, iord, mrd, mwr, irw, rdst, rw, m2r, asa;
    logic [1:0] asb, aop, psrc;
    logic       done, trap;
    logic [1:0] cause;
  } ctl_t;

  typedef struct {
    logic [63:0] tag;
    logic [5:0]  opc;
    logic        rdy;
    ctl_t        exp;
  } vec_t;

  // Expected outputs per state, straight from the control table.
  localparam ctl_t FW   = '{mrd:1'b1, asb:2'b01, default:'0};
  localparam ctl_t FG   = '{pcw:1'b1, mrd:1'b1, irw:1'b1, asb:2'b01, default:'0};
  localparam ctl_t DEC  = '{asb:2'b11, default:'0};
  localparam ctl_t MADR = '{asa:1'b1, asb:2'b10, default:'0};
  localparam ctl_t MRD  = '{iord:1'b1, mrd:1'b1, default:'0};
  localparam ctl_t MWB  = '{rw:1'b1, m2r:1'b1, done:1'b1, default:'0};
  localparam ctl_t MWRW = '{iord:1'b1, mwr:1'b1, default:'0};
  localparam ctl_t MWRG = '{iord:1'b1, mwr:1'b1, done:1'b1, default:'0};
  localparam ctl_t REX  = '{asa:1'b1, aop:2'b10, default:'0};
  localparam ctl_t RWB  = '{rdst:1'b1, rw:1'b1, done:1'b1, default:'0};
  localparam ctl_t IEX  = '{asa:1'b1, asb:2'b10, default:'0};
  localparam ctl_t IWB  = '{rw:1'b1, done:1'b1, default:'0};
  localparam ctl_t BEQ  = '{asa:1'b1, aop:2'b01, psrc:2'b01, pceq:1'b1, done:1'b1, default:'0};
  localparam ctl_t BNE  = '{asa:1'b1, aop:2'b01, psrc:2'b01, pcne:1'b1, done:1'b1, default:'0};
  localparam ctl_t TRP1 = '{pcw:1'b1, psrc:2'b11, done:1'b1, trap:1'b1, cause:2'b01, default:'0};
  localparam ctl_t TRP2 = '{pcw:1'b1, psrc:2'b11, done:1'b1, trap:1'b1, cause:2'b10, default:'0};
  localparam ctl_t JMP  = '{pcw:1'b1, psrc:2'b10, done:1'b1, default:'0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];
  ctl_t sb[$];

  mips_multicycle_control_if #(.ALU_OP_W(2)) bus ();

  mips_multicycle_control #(.MEM_TIMEOUT(TO), .ALU_OP_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t sample();
    ctl_t s;
    s.pcw   = bus.pc_write;    s.pceq = bus.pc_write_eq; s.pcne = bus.pc_write_ne;
    s.iord  = bus.i_or_d;      s.mrd  = bus.mem_read;    s.mwr  = bus.mem_write;
    s.irw   = bus.ir_write;    s.rdst = bus.reg_dst;     s.rw   = bus.reg_write;
    s.m2r   = bus.mem_to_reg;  s.asa  = bus.alu_src_a;   s.asb  = bus.alu_src_b;
    s.aop   = bus.alu_op;      s.psrc = bus.pc_source;   s.done = bus.instr_done;
    s.trap  = bus.trap;        s.cause = bus.trap_cause;
    return s;
  endfunction

  task automatic check(input string name, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic add(input logic [63:0] tag, input logic [5:0] o, input logic r,
                     input ctl_t e);
    vec_t v;
    v.tag = tag; v.opc = o; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t got;
    ctl_t exp;
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b0;

    // R-type, ready ignored (low) outside wait states
    add("rtype", 6'h00, 1'b1, FG);  add("rtype", 6'h00, 1'b0, DEC);
    add("rtype", 6'h00, 1'b0, REX); add("rtype", 6'h00, 1'b1, RWB);
    // addi
    add("addi", 6'h08, 1'b1, FG);   add("addi", 6'h08, 1'b1, DEC);
    add("addi", 6'h08, 1'b1, IEX);  add("addi", 6'h08, 1'b0, IWB);
    // lw with 3 wait cycles in MEM_RD (8 cycles total)
    add("lw", 6'h23, 1'b1, FG);     add("lw", 6'h23, 1'b1, DEC);
    add("lw", 6'h23, 1'b0, MADR);
    for (int k = 0; k < 3; k++) add("lw", 6'h23, 1'b0, MRD);
    add("lw", 6'h23, 1'b1, MRD);    add("lw", 6'h23, 1'b0, MWB);
    // sw with one wait
    add("sw", 6'h2b, 1'b1, FG);     add("sw", 6'h2b, 1'b1, DEC);
    add("sw", 6'h2b, 1'b1, MADR);   add("sw", 6'h2b, 1'b0, MWRW);
    add("sw", 6'h2b, 1'b1, MWRG);
    // branches
    add("beq", 6'h04, 1'b1, FG);    add("beq", 6'h04, 1'b1, DEC);
    add("beq", 6'h04, 1'b1, BEQ);
    add("bne", 6'h05, 1'b1, FG);    add("bne", 6'h05, 1'b1, DEC);
    add("bne", 6'h05, 1'b1, BNE);
    // illegal opcode
    add("illeg", 6'h3f, 1'b1, FG);  add("illeg", 6'h3f, 1'b1, DEC);
    add("illeg", 6'h3f, 1'b1, TRP1);
    // jump: traps as illegal unless the jump feature is built
    add("jump", 6'h02, 1'b1, FG);   add("jump", 6'h02, 1'b1, DEC);
`ifdef MC_CTRL_JUMP_EN
    add("jump", 6'h02, 1'b1, JMP);
`else
    add("jump", 6'h02, 1'b1, TRP1);
`endif
    // fetch timeout: TO wait cycles, then bus trap; ir_write never set
    for (int k = 0; k < TO; k++) add("fto", 6'h00, 1'b0, FW);
    add("fto", 6'h00, 1'b1, TRP2);
    // ready on the last allowed wait cycle completes normally
    for (int k = 0; k < TO - 1; k++) add("rwins", 6'h00, 1'b0, FW);
    add("rwins", 6'h00, 1'b1, FG);  add("rwins", 6'h00, 1'b1, DEC);
    add("rwins", 6'h00, 1'b1, REX); add("rwins", 6'h00, 1'b1, RWB);
    // store timeout
    add("swto", 6'h2b, 1'b1, FG);   add("swto", 6'h2b, 1'b1, DEC);
    add("swto", 6'h2b, 1'b1, MADR);
    for (int k = 0; k < TO; k++) add("swto", 6'h2b, 1'b0, MWRW);
    add("swto", 6'h2b, 1'b0, TRP2);
    add("after", 6'h00, 1'b0, FW);

    // reset state
    #2;
    check("reset_hold", sample(), FW);
    #10;          // t=12, between edges
    rst_n = 1'b1;
    #1;
    check("reset_release", sample(), FW);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.opcode    = vecs[i].opc;
      bus.mem_ready = vecs[i].rdy;
      sb.push_back(vecs[i].exp);
      #2;
      got = sample();
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got=0 exp=1");
      end else begin
        exp = sb.pop_front();
        check($sformatf("v%0d_%0s", i, vecs[i].tag), got, exp);
      end
    end

    // async reset during a store wait
    @(negedge clk); bus.opcode = 6'h2b; bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.mem_ready = 1'b0;
    #2;
    check("mwr_wait", sample(), MWRW);
    #1;
    rst_n = 1'b0;
    #1;
    check("mwr_async_drop", sample(), FW);
    @(negedge clk);
    #2;
    check("in_reset", sample(), FW);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("post_reset", sample(), FW);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
